alu_wb_stage: RTL

//  Consumer end of the ALU result interface: captures out/zero/neg/ovf plus dest register each cycle a

---
 rtl/alu_wb_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: captures ALU results and buffers them in a small FIFO that
// drains to the register-file write port. Also keeps the architectural status
// flags, raises the overflow trap and counts retired ALU ops.
module alu_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int DEPTH   = 2,
  parameter bit TRAP_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        aluop,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zero,
  input  logic              neg,
  input  logic              ovf,
  input  logic [RD_W-1:0]   rd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              flag_clr,
  output logic [2:0]        flags,
  output logic              trap,
  output logic [CNT_W-1:0]  op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [RD_W-1:0]   idx_q  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     rd_prev;
  logic [CW-1:0]     count_q, count_d;
  logic              z_q, n_q, v_q;
  logic              v_d;
  logic              trap_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept, arith, trap_hit, push, pop, empty;

  // Only the opcode class nibble matters here; the low nibble is intentionally ignored.
  logic unused_op_lo;
  assign unused_op_lo = ^aluop[3:0];

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign arith    = (aluop[7:4] == 4'b0001);
  assign trap_hit = TRAP_EN && arith && ovf;
  // Trapping ops and writes to the hard-wired r0 retire without a write-back.
  assign push     = accept && !trap_hit && (rd != '0);
  assign pop      = wb_valid && wb_ready;
  assign rd_prev  = rd_ptr_q - PW'(1);

  assign wb_valid = !empty;
  // When empty, keep presenting the most recently popped entry so the port holds its last value.
  assign wb_rd    = empty ? idx_q[rd_prev]  : idx_q[rd_ptr_q];
  assign wb_data  = empty ? data_q[rd_prev] : data_q[rd_ptr_q];
  assign flags    = {v_q, n_q, z_q};
  assign trap     = trap_q;
  assign op_count = cnt_q;

  // Next-state for FIFO pointers/occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    v_d      = v_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    // Setting by a new arithmetic overflow takes priority over the clear request.
    if (accept && arith && ovf) v_d = 1'b1;
    else if (flag_clr)          v_d = 1'b0;
  end

  // Control state: pointers, occupancy, flags, trap pulse, retired-op counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      trap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      v_q      <= v_d;
      trap_q   <= accept && trap_hit;
      if (accept) begin
        z_q   <= zero;
        n_q   <= neg;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the write port reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= alu_out;
      idx_q[wr_ptr_q]  <= rd;
    end
  end

endmodule
